// File: rtl/connector_pkg.sv
// connector_pkg: width helpers and round-robin search shared by the stream mux.
package connector_pkg;
  function automatic int chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int lvw(input int d);
    return $clog2(d) + 1;
  endfunction
  // Scanning from the far end down lets the nearest requester after ptr win.
  function automatic logic [3:0] rr_next(input logic [15:0] req, input logic [3:0] ptr, input int nch);
    logic [3:0] g;
    int idx;
    g = ptr;
    for (int k = 16; k >= 1; k--) begin
      idx = (int'(ptr) + k) % nch;
      if (k <= nch && req[idx[3:0]]) g = idx[3:0];
    end
    return g;
  endfunction
endpackage

// File: rtl/connector_chan_fifo.sv
// connector_chan_fifo: per-channel FIFO with wrap-bit pointers and occupancy.
module connector_chan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  localparam int LVW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [LVW-1:0]    level
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [LVW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic wr_en, rd_en;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[LVW-2:0] == rd_q[LVW-2:0]) && (wr_q[LVW-1] != rd_q[LVW-1]);
  assign level = wr_q - rd_q;
  assign dout = mem_q[rd_q[LVW-2:0]];
  // A pop on the same edge frees a slot, so a full FIFO may still accept.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  always_comb begin
    wr_d = wr_en ? wr_q + LVW'(1) : wr_q;
    rd_d = rd_en ? rd_q + LVW'(1) : rd_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q[LVW-2:0]] <= din;
endmodule

// File: rtl/connector_stream_mux.sv
// connector_stream_mux: NCH buffered write channels merged round-robin onto one
// valid/ready stream tagged with the source channel.
module connector_stream_mux
  import connector_pkg::*;
#(
  parameter int NCH = 3,
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  localparam int CHW = chw(NCH),
  localparam int LVW = lvw(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      wen,
  input  logic [NCH*DATA_W-1:0] data,
  input  logic                freeze,
  input  logic                clear_ovf,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic [CHW-1:0]      out_chan,
  output logic [NCH-1:0]      overflow,
  output logic [NCH*LVW-1:0]  level
);
  logic [DATA_W-1:0] dout [NCH];
  logic [NCH-1:0] empty, full, pop;
  logic [CHW-1:0] ptr_q, ptr_d, chan_q, chan_d, grant;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, load_en, load;
  logic [NCH-1:0] ovf_q, ovf_d;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    connector_chan_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(wen[i]), .pop(pop[i]),
      .din(data[i*DATA_W +: DATA_W]), .dout(dout[i]),
      .empty(empty[i]), .full(full[i]), .level(level[i*LVW +: LVW])
    );
    assign pop[i] = load && (grant == CHW'(i));
  end
  assign load_en = !freeze && (!valid_q || out_ready);
  assign load = load_en && !(&empty);
  assign grant = CHW'(rr_next(16'(~empty), 4'(ptr_q), NCH));
  // An idle register or a completed transfer under freeze drops valid.
  always_comb begin
    valid_d = load ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    data_d = load ? dout[grant] : data_q;
    chan_d = load ? grant : chan_q;
    ptr_d = load ? grant : ptr_q;
    ovf_d = (clear_ovf ? '0 : ovf_q) | (wen & full & ~pop);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
      ptr_q <= CHW'(NCH - 1);
      ovf_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      chan_q <= chan_d;
      ptr_q <= ptr_d;
      ovf_q <= ovf_d;
    end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_chan = chan_q;
  assign overflow = ovf_q;
endmodule

// File: doc/connector_stream_mux.md
Name: connector_stream_mux

Overview:
- Parametrised successor to the fixed 3-channel connector.
- Accepts NCH independent write channels (wen + data), buffers each in a per-channel FIFO and merges them onto one valid/ready output stream.
- Arbitration is round-robin; each output word carries its source channel index.
- Adds freeze, per-channel sticky overflow and occupancy reporting; sits between the top-level pin connector and downstream consumers.

Parameters:
- NCH, 3: number of input channels (1..16).
- DATA_W, 8: data width per channel.
- DEPTH, 4: per-channel FIFO depth; power of 2, >= 2.
- CHW, max(1,$clog2(NCH)): channel-index width (localparam).
- LVW, $clog2(DEPTH)+1: occupancy width (localparam).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wen  in  NCH  per-channel write enable; bit i belongs to channel i.
- data  in  NCH*DATA_W  channel i occupies [i*DATA_W +: DATA_W].
- freeze  in  1  when high, no new words are loaded into the output register.
- clear_ovf  in  1  clears all overflow flags.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W  output word.
- out_chan  out  CHW  source channel of out_data.
- overflow  out  NCH  sticky per-channel drop flag.
- level  out  NCH*LVW  per-channel FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, sync release): all FIFOs empty, level=0, out_valid=0, out_data=0, out_chan=0, overflow=0, RR pointer = NCH-1, so channel 0 has first priority.
- Push: wen[i]=1 at a rising edge writes data[i] into FIFO i unless it is full.
  - If FIFO i is full and not popped on that edge, the word is dropped and overflow[i] is set.
  - If FIFO i is full and popped on the same edge, the push is accepted and no overflow occurs.
- Output register:
  - load_en = !freeze && (!out_valid || out_ready).
  - On a load_en edge, the arbiter picks the first non-empty channel, searching from ptr+1 and wrapping modulo NCH. It pops that FIFO, loads out_data/out_chan, sets out_valid=1 and sets ptr = the granted channel.
  - If no channel is non-empty, out_valid clears when out_ready was high; otherwise it holds.
- Handshake:
  - A transfer occurs on an edge where out_valid && out_ready.
  - out_data and out_chan stay stable while out_valid && !out_ready.
  - Back-to-back transfers are sustained at one word per cycle.
- Latency: a word pushed at edge t into an empty system appears with out_valid=1 after edge t+1.
- Freeze:
  - Blocks loads only.
  - A word already valid may still complete its handshake; out_valid then drops to 0 and stays 0 until freeze deasserts.
  - Pushes continue during freeze and may overflow.
- Overflow:
  - Sticky until clear_ovf.
  - If a drop and clear_ovf occur on the same edge, set wins.
- Level:
  - Registered.
  - Updates on the edge after a push/pop: +1 for a push, -1 for a pop, unchanged for simultaneous push+pop.
- FIFO pointers are LVW bits wide; they wrap at DEPTH with the extra bit distinguishing full from empty.
- Reset asserted mid-transfer discards all buffered words; no partial output is ever presented.

Decomposition:
- Package connector_pkg holds:
  - the CHW/LVW width helper functions;
  - the rr_next function (round-robin search).
- One sub-module, connector_chan_fifo, instantiated NCH times:
  - parameters DATA_W, DEPTH;
  - ports clk, reset, push, pop, din, dout, empty, full, level.
- Arbiter and output register live in connector_stream_mux.

Test Plan:
- Single word: reset, then wen[1]=1, data1=0x5A for one cycle with out_ready=1 -> out_valid=1 two cycles later with out_data=0x5A, out_chan=1; level[1] goes 1 then 0.
- Round-robin: all three channels write 0x10/0x20/0x30 in the same cycle, out_ready=1 -> outputs in order ch0, ch1, ch2, one per cycle; a second simultaneous burst continues ch0, ch1, ch2.
- Backpressure: out_ready=0 for 5 cycles with a word valid -> out_data/out_chan held constant; releasing out_ready drains with no loss or duplication.
- Overflow: out_ready=0, 6 writes to ch2 (0x01..0x06) with DEPTH=4 -> level[2]=4, overflow[2]=1. Draining yields the held word, then 0x02..0x05 or equivalent with nothing past DEPTH+1 accepted. Exact expected sequence: 0x01 in the output register, then 0x02..0x05 buffered, 0x06 dropped. clear_ovf then clears the flag.
- Full with simultaneous push and pop: ch0 full, out_ready=1, wen[0]=1 -> no overflow; level stays 4.
- Freeze and reset: freeze=1 while ch0 holds 2 words -> out_valid stays 0 and writes continue. Deassert freeze -> words emerge in FIFO order. Assert reset mid-burst -> all outputs 0 immediately (asynchronous) and level=0.
